// File: rtl/pong_pkg.sv
// pong_pkg: definitions shared by the paddle, ball and render logic.
//   - Screen geometry defaults (visible lines, paddle height).
//   - Paddle FSM state encoding and button direction encoding.
//   - decode_dir(): turns the two button levels into one direction.
package pong_pkg;

    localparam int SCREEN_H_DEF = 480;
    localparam int PADDLE_H_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2
    } paddle_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // Both buttons or neither pressed both count as "no direction".
    function automatic dir_t decode_dir(input logic up, input logic down);
        dir_t d;
        if (up && !down) begin
            d = DIR_UP;
        end else if (down && !up) begin
            d = DIR_DOWN;
        end else begin
            d = DIR_NONE;
        end
        return d;
    endfunction

endpackage

// File: rtl/paddle_ctrl_sat_step.sv
// sat_step: combinational saturating position update.
//   i_pos  [9:0] current paddle top-edge line
//   i_step [9:0] lines to move (0 = stay)
//   i_up         1 = move toward line 0, 0 = move toward Y_MAX
//   o_pos  [9:0] new position clamped to [0, Y_MAX]
module sat_step #(
    parameter int Y_MAX = 416
) (
    input  logic [9:0] i_pos,
    input  logic [9:0] i_step,
    input  logic       i_up,
    output logic [9:0] o_pos
);

    localparam logic [10:0] MAX11 = 11'(Y_MAX);

    logic [10:0] w_sum;
    logic [10:0] w_diff;

    always_comb begin
        w_sum  = {1'b0, i_pos} + {1'b0, i_step};
        w_diff = {1'b0, i_pos} - {1'b0, i_step};
        if (i_up) begin
            // Bit 10 is the borrow: the subtraction went below zero.
            o_pos = w_diff[10] ? '0 : w_diff[9:0];
        end else begin
            o_pos = (w_sum > MAX11) ? MAX11[9:0] : w_sum[9:0];
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: one player's paddle position controller.
// Buttons are sampled once per video frame; holding a direction moves the
// paddle slowly, and after HOLD_FRAMES consecutive frames it moves fast.
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_up/i_down  debounced buttons, high = pressed
//   i_frame_tick one-cycle pulse per frame; all state advances only here
//   o_paddle_y   paddle top-edge line (registered)
//   o_moving     high while in SLOW or FAST (registered)
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_H    = SCREEN_H_DEF,
    parameter int PADDLE_H    = PADDLE_H_DEF,
    parameter int STEP_SLOW   = 2,
    parameter int STEP_FAST   = 6,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_frame_tick,
    output logic [9:0] o_paddle_y,
    output logic       o_moving
);

    localparam int               Y_MAX   = SCREEN_H - PADDLE_H;
    localparam logic [9:0]       Y_RESET = 10'(Y_MAX / 2);
    localparam int               CNT_W   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_FRAMES - 1);

    paddle_state_t    r_state;
    paddle_state_t    w_state_nxt;
    dir_t             r_dir;
    dir_t             w_dir;
    dir_t             w_dir_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_hold_inc;
    logic [9:0]       r_y;
    logic             r_moving;
    logic [9:0]       w_step;
    logic [9:0]       w_y_nxt;

    assign w_dir = decode_dir(i_up, i_down);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_hold_nxt  = r_hold;
        w_hold_inc  = (r_hold >= CNT_TOP) ? CNT_TOP : r_hold + 1'b1;
        w_step      = '0;

        if (i_frame_tick) begin
            if (w_dir == DIR_NONE) begin
                w_state_nxt = ST_IDLE;
                w_dir_nxt   = DIR_NONE;
                w_hold_nxt  = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_SLOW;
                        w_dir_nxt   = w_dir;
                        w_hold_nxt  = '0;
                    end
                    ST_SLOW: begin
                        if (w_dir != r_dir) begin
                            w_dir_nxt  = w_dir;
                            w_hold_nxt = '0;
                        end else begin
                            // The frame whose increment reaches the top is
                            // already moved at the fast rate.
                            w_hold_nxt = w_hold_inc;
                            if (w_hold_inc == CNT_TOP) begin
                                w_state_nxt = ST_FAST;
                            end
                        end
                    end
                    ST_FAST: begin
                        if (w_dir != r_dir) begin
                            w_state_nxt = ST_SLOW;
                            w_dir_nxt   = w_dir;
                            w_hold_nxt  = '0;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_dir_nxt   = DIR_NONE;
                        w_hold_nxt  = '0;
                    end
                endcase
            end

            case (w_state_nxt)
                ST_SLOW: w_step = 10'(STEP_SLOW);
                ST_FAST: w_step = 10'(STEP_FAST);
                default: w_step = '0;
            endcase
        end
    end

    sat_step #(
        .Y_MAX(Y_MAX)
    ) u_sat_step (
        .i_pos (r_y),
        .i_step(w_step),
        .i_up  (w_dir == DIR_UP),
        .o_pos (w_y_nxt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_NONE;
            r_hold   <= '0;
            r_y      <= Y_RESET;
            r_moving <= 1'b0;
        end else if (i_frame_tick) begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_hold   <= w_hold_nxt;
            r_y      <= w_y_nxt;
            r_moving <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_paddle_y = r_y;
    assign o_moving   = r_moving;

endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;

    localparam int Y_MAX   = 416;
    localparam int Y_RST   = 208;
    localparam int STEP_S  = 2;
    localparam int STEP_F  = 6;
    localparam int HOLD    = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       down;
    logic       tick;
    logic [9:0] y;
    logic       mv;

    paddle_ctrl #(
        .SCREEN_H   (480),
        .PADDLE_H   (64),
        .STEP_SLOW  (STEP_S),
        .STEP_FAST  (STEP_F),
        .HOLD_FRAMES(HOLD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_up        (up),
        .i_down      (down),
        .i_frame_tick(tick),
        .o_paddle_y  (y),
        .o_moving    (mv)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: speed depends only on how many consecutive frames
    // the same single direction has been held (run length).
    int m_y;
    int m_run;
    int m_dir;   // 0 none, 1 up, 2 down
    bit m_mv;

    typedef struct {
        bit u;
        bit d;
        bit t;
        int exp_y;
        bit exp_mv;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_y   = Y_RST;
        m_run = 0;
        m_dir = 0;
        m_mv  = 1'b0;
    endtask

    task automatic model_tick(input bit u, input bit d);
        int dir;
        int step;
        dir = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
        if (dir == 0) begin
            m_run = 0;
            m_dir = 0;
            m_mv  = 1'b0;
        end else begin
            if (dir == m_dir && m_run > 0) m_run++;
            else m_run = 1;
            m_dir = dir;
            m_mv  = 1'b1;
            step  = (m_run >= HOLD) ? STEP_F : STEP_S;
            if (dir == 1) m_y = (m_y - step < 0) ? 0 : m_y - step;
            else          m_y = (m_y + step > Y_MAX) ? Y_MAX : m_y + step;
        end
    endtask

    // Called at posedge+1: drives inputs, advances the model, checks after the edge.
    task automatic cycle(input bit u, input bit d, input bit t, input string tag);
        up   = u;
        down = d;
        tick = t;
        if (t) model_tick(u, d);
        @(posedge clk);
        #1;
        check({tag, " y"}, int'(y), m_y);
        check({tag, " mv"}, int'(mv), int'(m_mv));
    endtask

    task automatic do_reset();
        up   = 1'b0;
        down = 1'b0;
        tick = 1'b0;
        rst  = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset y", int'(y), Y_RST);
        check("reset mv", int'(mv), 0);
    endtask

    initial begin
        rst  = 1'b1;
        up   = 1'b0;
        down = 1'b0;
        tick = 1'b0;
        model_reset();

        vecs[0]  = '{1, 0, 1, 206, 1};
        vecs[1]  = '{1, 0, 1, 204, 1};
        vecs[2]  = '{1, 0, 1, 202, 1};
        vecs[3]  = '{1, 1, 1, 202, 0};
        vecs[4]  = '{1, 0, 0, 202, 0};
        vecs[5]  = '{0, 1, 0, 202, 0};
        vecs[6]  = '{0, 0, 1, 202, 0};
        vecs[7]  = '{0, 1, 1, 204, 1};
        vecs[8]  = '{1, 0, 1, 202, 1};
        vecs[9]  = '{1, 0, 0, 202, 1};
        vecs[10] = '{0, 0, 1, 202, 0};

        @(posedge clk);
        #1;
        check("por y", int'(y), Y_RST);
        check("por mv", int'(mv), 0);
        rst = 1'b0;

        // Table-driven basic behaviour
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].u, vecs[i].d, vecs[i].t, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl_y", i), int'(y), vecs[i].exp_y);
            check($sformatf("vec%0d tbl_mv", i), int'(mv), int'(vecs[i].exp_mv));
        end

        // Hold down 30 ticks: slow for 29, fast on the 30th
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            cycle(0, 1, 1, "hold_dn");
            if (k == 29) check("dn tick29 y", int'(y), 266);
        end
        check("dn tick30 y", int'(y), 272);
        for (int k = 0; k < 30; k++) cycle(0, 1, 1, "fast_dn");
        check("clamp bottom y", int'(y), Y_MAX);
        check("clamp bottom mv", int'(mv), 1);
        // Reverse from FAST: slow upward, counter restarted
        cycle(1, 0, 1, "rev_up");
        check("reverse y", int'(y), 414);
        cycle(1, 0, 1, "rev_up2");
        check("reverse2 y", int'(y), 412);

        // Walk up in slow steps to y=4, then clamp at 0
        do_reset();
        for (int k = 0; k < 102; k++) begin
            cycle(1, 0, 1, "walk_up");
            cycle(0, 0, 1, "walk_rel");
        end
        check("walk y", int'(y), 4);
        cycle(1, 0, 1, "top1");
        check("top1 y", int'(y), 2);
        cycle(1, 0, 1, "top2");
        check("top2 y", int'(y), 0);
        cycle(1, 0, 1, "top3");
        check("top3 y", int'(y), 0);
        check("top3 mv", int'(mv), 1);

        // Tick held high for several cycles counts once per cycle
        do_reset();
        cycle(0, 1, 1, "tick_hi");
        cycle(0, 1, 1, "tick_hi");
        cycle(0, 1, 1, "tick_hi");
        check("tick held y", int'(y), 214);

        // Asynchronous reset mid-FAST
        do_reset();
        for (int k = 0; k < 32; k++) cycle(0, 1, 1, "pre_rst");
        check("pre_rst y", int'(y), 284);
        #2;
        rst = 1'b1;
        #1;
        check("async rst y", int'(y), Y_RST);
        check("async rst mv", int'(mv), 0);
        up   = 1'b0;
        down = 1'b0;
        tick = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 0, 1, "post_rst");
        check("post_rst y", int'(y), 206);

        // Randomized against the model
        do_reset();
        begin
            bit ru;
            bit rd;
            int sel;
            ru = 1'b0;
            rd = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(15) == 0) begin
                    sel = $urandom_range(7);
                    ru  = (sel <= 2) || (sel == 6);
                    rd  = (sel >= 3 && sel <= 6);
                end
                if ($urandom_range(599) == 0) do_reset();
                else cycle(ru, rd, $urandom_range(2) != 0, "rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_H, default 480: visible lines.
REQ-002 SHALL have parameter PADDLE_H, default 64: paddle height in lines.
REQ-003 SHALL have parameter STEP_SLOW, default 2: lines moved per frame in SLOW.
REQ-004 SHALL have parameter STEP_FAST, default 6: lines moved per frame in FAST.
REQ-005 SHALL have parameter HOLD_FRAMES, default 30: consecutive moving frames before FAST.
REQ-006 SHALL have port i_clk  input  1  single system clock (12 MHz); one clock; all logic on posedge i_clk.
REQ-007 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_up  input  1  debounced up button, synchronous to i_clk, high = pressed.
REQ-009 SHALL have port i_down  input  1  debounced down button, synchronous to i_clk, high = pressed.
REQ-010 SHALL have port i_frame_tick  input  1  one-cycle pulse once per video frame.
REQ-011 SHALL have port o_paddle_y  output  10  paddle top-edge line, registered.
REQ-012 SHALL have port o_moving  output  1  high while state is SLOW or FAST, registered.

Function
REQ-013 SHALL sample i_up/i_down and update all state only in cycles where i_frame_tick=1; other cycles hold everything.
REQ-014 SHALL decode direction per tick: UP = i_up&~i_down, DOWN = i_down&~i_up, NONE otherwise (both or neither pressed).
REQ-015 SHALL implement FSM states IDLE, SLOW, FAST.
REQ-016 SHALL transition on tick: IDLE->SLOW on UP/DOWN; any state->IDLE on NONE; SLOW->FAST when hold count reaches HOLD_FRAMES-1 with same direction; SLOW/FAST->SLOW on direction reversal.
REQ-017 SHALL keep a hold counter: cleared on IDLE entry and on reversal, incremented each tick in SLOW with unchanged direction, saturating at HOLD_FRAMES-1.
REQ-018 SHALL apply movement in the same tick as the transition: step = STEP_FAST if next state is FAST, STEP_SLOW if next state is SLOW, 0 if IDLE.
REQ-019 SHALL decrease o_paddle_y for UP and increase it for DOWN, computed in 11-bit width before clamping.
REQ-020 SHALL clamp o_paddle_y to [0, SCREEN_H-PADDLE_H] (0..416 at defaults); never wrap.
REQ-021 SHALL keep FSM state and counter advancing when clamped at a limit (o_moving stays high while a button is held).
REQ-022 SHALL present updated o_paddle_y and o_moving one cycle after the tick cycle (latency 1).
REQ-023 SHALL treat i_frame_tick held high for multiple cycles as one tick per cycle (no edge detection).

Reset
REQ-024 SHALL, on i_rst=1, immediately set o_paddle_y=(SCREEN_H-PADDLE_H)/2 (208), o_moving=0, state=IDLE, hold counter=0.
REQ-025 SHALL abandon any motion in progress when reset asserts mid-operation; first tick after release behaves as from IDLE.

Structure
REQ-026 SHALL place FSM state encoding and screen-geometry defaults (SCREEN_H, PADDLE_H) in shared package pong_pkg, reused by ball and render logic.
REQ-027 SHALL instantiate one sub-module, sat_step: 10-bit position, step, direction in; clamped position out (combinational).
REQ-028 SHALL be instantiated once per player, fed directly by debounce outputs.

Verification
REQ-029 SHALL cover: reset, hold i_up for 3 ticks -> o_paddle_y 208,206,204,202; o_moving=1.
REQ-030 SHALL cover: hold i_down 30 ticks -> first 29 ticks step 2, tick 30 onward step 6 (y=208+58+6=272 after tick 30).
REQ-031 SHALL cover: y=4, i_up held -> y=2,0,0; o_moving stays 1; no wrap to 1023.
REQ-032 SHALL cover: FAST down, switch to i_up -> next tick step 2 upward, counter cleared.
REQ-033 SHALL cover: both buttons pressed -> y unchanged, o_moving=0; buttons toggled without i_frame_tick -> no change.
REQ-034 SHALL cover: i_rst pulsed mid-FAST between clock edges -> o_paddle_y=208, o_moving=0 asynchronously.
